alu_uart_ctrl: RTL

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

---
 rtl/alu_uart_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_uart_ctrl.sv
// Collects a three-byte command (A, B, opcode) from a UART receiver, drives an
// external ALU, and sends back the result byte followed by a status byte.
module alu_uart_ctrl #(
    parameter int bits    = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done,
    input  logic [7:0]      rx_data,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    input  logic            tx_done,
    output logic [bits-1:0] alu_A,
    output logic [bits-1:0] alu_B,
    output logic [3:0]      alu_select,
    input  logic [bits-1:0] alu_C,
    input  logic            alu_zero,
    output logic            busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_STAT,
        WAIT_STAT
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [bits-1:0] r_aluA;
    logic [bits-1:0] r_aluB;
    logic [3:0]      r_aluSel;
    logic [bits-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;
    logic [CW-1:0]   r_timer;
    logic            w_collecting;
    logic            w_expired;
    logic            w_illegal;
    logic [7:0]      w_status;

    assign w_collecting = (r_state == GET_B) || (r_state == GET_OP);
    assign w_expired    = w_collecting && (r_timer == CW'(TIMEOUT - 1));
    assign w_illegal    = !(r_aluSel inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                             4'd5, 4'd6, 4'd9, 4'd11});
    assign w_status     = {6'b0, r_illegal, r_zero};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:      if (rx_done) w_nextState = GET_B;
            GET_B: begin
                if (rx_done)        w_nextState = GET_OP;
                else if (w_expired) w_nextState = IDLE;
            end
            GET_OP: begin
                if (rx_done)        w_nextState = EXEC;
                else if (w_expired) w_nextState = IDLE;
            end
            EXEC:      w_nextState = SEND_RES;
            SEND_RES:  w_nextState = WAIT_RES;
            WAIT_RES:  if (tx_done) w_nextState = SEND_STAT;
            SEND_STAT: w_nextState = WAIT_STAT;
            WAIT_STAT: if (tx_done) w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aluA    <= '0;
            r_aluB    <= '0;
            r_aluSel  <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE:   if (rx_done) r_aluA <= bits'(rx_data);
                GET_B:  if (rx_done) r_aluB <= bits'(rx_data);
                GET_OP: if (rx_done) r_aluSel <= rx_data[3:0];
                EXEC: begin
                    r_result  <= alu_C;
                    r_zero    <= alu_zero;
                    r_illegal <= w_illegal;
                end
                default: ;
            endcase
        end
    end

    // Inter-byte timer: runs only while a frame is partially received.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_collecting && !rx_done && !w_expired) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    assign tx_start   = (r_state == SEND_RES) || (r_state == SEND_STAT);
    assign tx_data    = ((r_state == SEND_STAT) || (r_state == WAIT_STAT))
                        ? w_status : 8'(r_result);
    assign busy       = (r_state != IDLE);
    assign alu_A      = r_aluA;
    assign alu_B      = r_aluB;
    assign alu_select = r_aluSel;

endmodule
